sliding_window_pattern_generator: RTL and testbench

Serial frame transmitter that drives the input of the team's 1110_0111 sliding-window sequence detector. Each accepted byte is sent as a fixed 8-bit sync preamble (default 1110_0111), then 8 payload bits MSB-first, then a run of idle zeros. Upstream logic loads bytes through a valid/ready handshake. The block provides the stimulus and loopback source for detector-side testing.

---
 rtl/sliding_window_pattern_generator.sv | 133 +++++++++++++
 tb/tb_sliding_window_pattern_generator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_pattern_generator.sv
// Serial frame transmitter: sync preamble, MSB-first payload byte, then idle zeros.
// Drives the 1110_0111 sliding-window detector; bytes arrive over a valid/ready handshake.
`timescale 1ns/1ps
module sliding_window_pattern_generator #(
    parameter logic [7:0] PATTERN    = 8'b1110_0111,
    parameter int         GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out,
    output logic       out_valid,
    output logic       frame_done,
    output logic [2:0] test_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        GAP  = 3'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       accept;

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            gap_cnt_q    <= 4'd0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SYNC;
                    shift_d   = in_data;
                    bit_cnt_d = 3'd0;
                    gap_cnt_d = 4'd0;
                end
            end
            SYNC: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            DATA: begin
                shift_d = {shift_q[6:0], 1'b0};
                if (bit_cnt_q == 3'd7) begin
                    state_d   = GAP;
                    bit_cnt_d = 3'd0;
                    gap_cnt_d = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                shift_d   = 8'd0;
                bit_cnt_d = 3'd0;
                gap_cnt_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they land in a flop the same edge.
    always_comb begin
        out_d        = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_d)
            SYNC: begin
                out_d       = PATTERN[3'd7 - bit_cnt_d];
                out_valid_d = 1'b1;
            end
            DATA: begin
                out_d        = shift_d[7];
                out_valid_d  = 1'b1;
                frame_done_d = (bit_cnt_d == 3'd7);
            end
            default: ;
        endcase
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign test_state = state_q;

endmodule

// File: tb/tb_sliding_window_pattern_generator.sv
// Self-checking bench for sliding_window_pattern_generator: directed scenarios plus
// randomized traffic against a frame-level reference model and a loopback detector model.
`timescale 1ns/1ps
module tb_sliding_window_pattern_generator;

    localparam logic [7:0] PATTERN    = 8'b1110_0111;
    localparam int         GAP_CYCLES = 2;
    localparam int         FRAME_LEN  = 16 + GAP_CYCLES;
    localparam logic [6:0] IDLE_VEC   = 7'b0001_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out;
    logic       out_valid;
    logic       frame_done;
    logic [2:0] test_state;
    logic [6:0] obs;
    logic [7:0] det_window;
    logic       dec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sliding_window_pattern_generator #(
        .PATTERN    (PATTERN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .test_state (test_state)
    );

    assign obs = {out, out_valid, frame_done, in_ready, test_state};

    // Behavioural 1110_0111 detector: flags when the last seven sampled bits plus the current bit match.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_window <= 8'd0;
        else        det_window <= {det_window[6:0], out};
    end
    assign dec = ({det_window[6:0], out} == PATTERN);

    // Expected {out, out_valid, frame_done, in_ready, test_state} at position pos of a frame carrying b.
    function automatic logic [6:0] exp_vec(input logic [7:0] b, input int pos);
        logic [15:0] word;
        logic        bit_v;
        logic        valid_v;
        logic        done_v;
        logic [2:0]  st;
        word = {PATTERN, b};
        if (pos < 0 || pos >= FRAME_LEN) return IDLE_VEC;
        valid_v = (pos < 16);
        done_v  = (pos == 15);
        bit_v   = valid_v ? word[15 - pos] : 1'b0;
        if (pos < 8)       st = 3'd1;
        else if (pos < 16) st = 3'd2;
        else               st = 3'd3;
        return {bit_v, valid_v, done_v, 1'b0, st};
    endfunction

    task automatic test_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_assert: got %b want %b", obs, 7'b0);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want %b", obs, IDLE_VEC);
        end
        @(negedge clk);
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL reset_idle_hold: got %b want %b", obs, IDLE_VEC);
        end
    endtask

    task automatic test_single_frame();
        int done_count;
        done_count = 0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int k = 0; k <= FRAME_LEN; k++) begin
            checks++;
            if (obs !== exp_vec(8'hA5, k)) begin
                errors++;
                $display("[TB] FAIL single_frame[%0d]: got %b want %b", k, obs, exp_vec(8'hA5, k));
            end
            if (frame_done === 1'b1) done_count++;
            @(negedge clk);
        end
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("[TB] FAIL single_frame_done_count: got %0d want 1", done_count);
        end
    endtask

    task automatic test_back_to_back();
        int       starts[$];
        int       done_count;
        logic     prev_valid;
        logic [7:0] b;
        int       pos;
        done_count = 0;
        prev_valid = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        @(negedge clk);
        for (int k = 0; k <= 2 * FRAME_LEN + 2; k++) begin
            if (k < FRAME_LEN + 1) begin
                b   = 8'hFF;
                pos = k;
            end else begin
                b   = 8'h00;
                pos = k - (FRAME_LEN + 1);
            end
            checks++;
            if (obs !== exp_vec(b, pos)) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %b want %b", k, obs, exp_vec(b, pos));
            end
            if (out_valid === 1'b1 && prev_valid !== 1'b1) starts.push_back(k);
            if (frame_done === 1'b1) done_count++;
            prev_valid = out_valid;
            if (k == 0)             in_data  = 8'h00;
            if (k == FRAME_LEN + 1) in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (starts.size() != 2 || starts[1] - starts[0] != FRAME_LEN + 1) begin
            errors++;
            $display("[TB] FAIL back_to_back_spacing: got %0d starts, spacing %0d want %0d",
                     starts.size(), (starts.size() >= 2) ? starts[1] - starts[0] : -1, FRAME_LEN + 1);
        end
        checks++;
        if (done_count !== 2) begin
            errors++;
            $display("[TB] FAIL back_to_back_done_count: got %0d want 2", done_count);
        end
    endtask

    task automatic test_busy_ignore();
        in_valid = 1'b1;
        in_data  = 8'h96;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int k = 0; k <= FRAME_LEN + 2; k++) begin
            checks++;
            if (obs !== exp_vec(8'h96, k)) begin
                errors++;
                $display("[TB] FAIL busy_ignore[%0d]: got %b want %b", k, obs, exp_vec(8'h96, k));
            end
            if (k == 3 || k == FRAME_LEN - 2) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_frame_reset();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            checks++;
            if (obs !== exp_vec(8'h5A, k)) begin
                errors++;
                $display("[TB] FAIL mid_reset_pre[%0d]: got %b want %b", k, obs, exp_vec(8'h5A, k));
            end
            if (k < 11) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_drop: got %b want %b", obs, 7'b0);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("[TB] FAIL mid_reset_release: got %b want %b", obs, IDLE_VEC);
        end
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int k = 0; k <= FRAME_LEN; k++) begin
            checks++;
            if (obs !== exp_vec(8'h81, k)) begin
                errors++;
                $display("[TB] FAIL mid_reset_frame[%0d]: got %b want %b", k, obs, exp_vec(8'h81, k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        int dec_count;
        int pos;
        dec_count = 0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        for (int k = 0; k < 3 * (FRAME_LEN + 1); k++) begin
            pos = k % (FRAME_LEN + 1);
            checks++;
            if (dec !== (pos == 7)) begin
                errors++;
                $display("[TB] FAIL loopback_dec[%0d]: got %b want %b", k, dec, (pos == 7));
            end
            checks++;
            if (obs !== exp_vec(8'h00, pos)) begin
                errors++;
                $display("[TB] FAIL loopback_out[%0d]: got %b want %b", k, obs, exp_vec(8'h00, pos));
            end
            if (dec === 1'b1) dec_count++;
            if (k == 2 * (FRAME_LEN + 1)) in_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dec_count !== 3) begin
            errors++;
            $display("[TB] FAIL loopback_dec_count: got %0d want 3", dec_count);
        end
    endtask

    task automatic test_random_traffic();
        logic [6:0] exp_q[$];
        logic [6:0] expv;
        logic       was_idle;
        int         frames;
        frames   = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            expv = (exp_q.size() > 0) ? exp_q[0] : IDLE_VEC;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %b want %b", c, obs, expv);
            end
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            if (was_idle && in_valid) begin
                frames++;
                for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(exp_vec(in_data, i));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("[TB] random traffic sent %0d frames", frames);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_mid_frame_reset();
        test_loopback();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
